// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with round-robin or fixed-priority arbitration.
// Winning channel's beat is captured into a single registered output slot.

module rr_stream_mux_lane #(
    parameter int WIDTH = 4
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] masked
);
    // AND-masking keeps X on non-granted channels out of the OR tree.
    assign masked = data & {WIDTH{sel}};
endmodule

module rr_stream_mux #(
    parameter  int WIDTH = 4,
    parameter  int N     = 4,
    parameter  int RR    = 1,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel
);
    logic [SEL_W-1:0]            ptr;
    logic [SEL_W-1:0]            gidx;
    logic [SEL_W-1:0]            idx;
    logic [SEL_W-1:0]            ptr_nxt;
    logic                        found;
    logic                        any;
    logic                        load;
    logic [N-1:0]                gnt;
    logic [N-1:0][WIDTH-1:0]     lane_data;
    logic [WIDTH-1:0]            mux_data;

    assign any  = |in_valid;
    assign load = !out_valid || out_ready;

    // First valid channel at or above ptr, wrapping past N-1.
    always_comb begin
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = SEL_W'((int'(ptr) + k) % N);
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            assign gnt[i] = any && (gidx == SEL_W'(i));
            rr_stream_mux_lane #(.WIDTH(WIDTH)) u_lane (
                .sel    (gnt[i]),
                .data   (in_data[i*WIDTH +: WIDTH]),
                .masked (lane_data[i])
            );
        end
    endgenerate

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) mux_data = mux_data | lane_data[i];
    end

    assign in_ready = (rst || !load) ? '0 : gnt;
    assign ptr_nxt  = (gidx == SEL_W'(N - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_sel   <= gidx;
                if (RR != 0) ptr <= ptr_nxt;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: three configurations (N=4 RR, N=3 RR, N=4 fixed) against
// a cycle-level behavioural model plus directed literal expectations.

module tb_rr_stream_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  v0, ir0, od0, v2, ir2, od2, od1;
    logic [2:0]  v1, ir1;
    logic [15:0] d0, d2;
    logic [11:0] d1;
    logic        r0, r1, r2, ov0, ov1, ov2;
    logic [1:0]  os0, os1, os2;

    int tests = 0;
    int fails = 0;

    rr_stream_mux u0 (.clk(clk), .rst(rst), .in_valid(v0), .in_ready(ir0), .in_data(d0),
                      .out_valid(ov0), .out_ready(r0), .out_data(od0), .out_sel(os0));
    rr_stream_mux #(.N(3)) u1 (.clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_data(d1),
                      .out_valid(ov1), .out_ready(r1), .out_data(od1), .out_sel(os1));
    rr_stream_mux #(.RR(0)) u2 (.clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .in_data(d2),
                      .out_valid(ov2), .out_ready(r2), .out_data(od2), .out_sel(os2));

    // Uniform views of the three instances for the model.
    logic [3:0]  va[3], ira[3], oda[3];
    logic [15:0] da[3];
    logic        ra[3], ova[3];
    logic [1:0]  osa[3];
    always_comb begin
        va[0] = v0;  va[1] = {1'b0, v1};   va[2] = v2;
        ira[0] = ir0; ira[1] = {1'b0, ir1}; ira[2] = ir2;
        oda[0] = od0; oda[1] = od1; oda[2] = od2;
        da[0] = d0;  da[1] = {4'h0, d1};   da[2] = d2;
        ra[0] = r0;  ra[1] = r1;  ra[2] = r2;
        ova[0] = ov0; ova[1] = ov1; ova[2] = ov2;
        osa[0] = os0; osa[1] = os1; osa[2] = os2;
    end

    function automatic int n_of(int i);
        return (i == 1) ? 3 : 4;
    endfunction

    function automatic bit rr_of(int i);
        return i != 2;
    endfunction

    // Circular search from p; -1 when nothing requests.
    function automatic int arb(int p, logic [3:0] v, int n);
        logic [3:0] t;
        for (int k = 0; k < n; k++) begin
            t = v >> ((p + k) % n);
            if (t[0]) return (p + k) % n;
        end
        return -1;
    endfunction

    int         m_ptr[3] = '{0, 0, 0};
    logic       m_ov[3]  = '{1'b0, 1'b0, 1'b0};
    logic [3:0] m_od[3]  = '{4'h0, 4'h0, 4'h0};
    int         m_os[3]  = '{0, 0, 0};

    function automatic logic [3:0] exp_ir(int i);
        int g;
        if (rst || (m_ov[i] && !ra[i])) return 4'b0000;
        g = arb(m_ptr[i], va[i], n_of(i));
        if (g < 0) return 4'b0000;
        return 4'b0001 << g;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_ptr[i] <= 0;
                m_ov[i]  <= 1'b0;
                m_od[i]  <= 4'h0;
                m_os[i]  <= 0;
            end else if (!m_ov[i] || ra[i]) begin
                if (arb(m_ptr[i], va[i], n_of(i)) >= 0) begin
                    m_ov[i] <= 1'b1;
                    m_od[i] <= 4'(da[i] >> (4 * arb(m_ptr[i], va[i], n_of(i))));
                    m_os[i] <= arb(m_ptr[i], va[i], n_of(i));
                    if (rr_of(i))
                        m_ptr[i] <= (arb(m_ptr[i], va[i], n_of(i)) + 1) % n_of(i);
                end else begin
                    m_ov[i] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d at %0t: got %h expected %h", name, inst, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk("model out_valid", i, 8'(ova[i]), 8'(m_ov[i]));
            if (m_ov[i]) begin
                chk("model out_data", i, 8'(oda[i]), 8'(m_od[i]));
                chk("model out_sel", i, 8'(osa[i]), 8'(m_os[i]));
            end
            chk("model in_ready", i, 8'(ira[i]), 8'(exp_ir(i)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        v0 = '0; v1 = '0; v2 = '0;
        d0 = 16'hDCBA; d1 = 12'hCBA; d2 = 16'hDCBA;
        r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
        step(); step();
        chk("reset out_valid", 0, 8'(ov0), 8'h00);
        chk("reset out_data", 0, 8'(od0), 8'h00);
        chk("reset out_sel", 0, 8'(os0), 8'h00);
        chk("reset in_ready", 0, 8'(ir0), 8'h00);
        rst = 1'b0;

        // Single-channel sweep
        for (int ch = 0; ch < 4; ch++) begin
            v0 = 4'b0001 << ch;
            step();
            chk("sweep out_valid", 0, 8'(ov0), 8'h01);
            chk("sweep out_data", 0, 8'(od0), 8'(4'hA + ch));
            chk("sweep out_sel", 0, 8'(os0), 8'(ch));
        end
        v0 = '0;
        step();
        chk("idle out_valid", 0, 8'(ov0), 8'h00);

        // Round-robin fairness
        v0 = 4'hF;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr out_sel", 0, 8'(os0), 8'(k % 4));
            chk("rr out_data", 0, 8'(od0), 8'(4'hA + k % 4));
        end
        v0 = '0;
        step();

        // Back-pressure
        v0 = 4'b0110;
        step();
        chk("bp first sel", 0, 8'(os0), 8'h01);
        r0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp in_ready", 0, 8'(ir0), 8'h00);
            step();
            chk("bp hold data", 0, 8'(od0), 8'h0B);
            chk("bp hold sel", 0, 8'(os0), 8'h01);
            chk("bp hold valid", 0, 8'(ov0), 8'h01);
        end
        r0 = 1'b1;
        #1;
        chk("bp release in_ready", 0, 8'(ir0), 8'h04);
        step();
        chk("bp release data", 0, 8'(od0), 8'h0C);
        chk("bp release sel", 0, 8'(os0), 8'h02);
        v0 = '0;
        step();

        // Skip and wrap on N=3
        v1 = 3'b100;
        step();
        chk("wrap grant2", 1, 8'(os1), 8'h02);
        v1 = 3'b001;
        step();
        chk("wrap grant0", 1, 8'(os1), 8'h00);
        v1 = 3'b011;
        step();
        chk("wrap grant1 first", 1, 8'(os1), 8'h01);
        chk("wrap data1", 1, 8'(od1), 8'h0B);
        step();
        chk("wrap grant0 next", 1, 8'(os1), 8'h00);
        v1 = '0;
        step();

        // Fixed priority
        v2 = 4'hF;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("fixed out_sel", 2, 8'(os2), 8'h00);
            chk("fixed out_data", 2, 8'(od2), 8'h0A);
        end
        v2 = '0;
        step();

        // Reset mid-operation, then X isolation
        d0 = 16'hD7BA;
        v0 = 4'b0100;
        step();
        chk("pre-rst data", 0, 8'(od0), 8'h07);
        v0 = '0;
        r0 = 1'b0;
        step();
        chk("pre-rst hold", 0, 8'(ov0), 8'h01);
        rst = 1'b1;
        r0 = 1'b1;
        v0 = 4'b1010;
        #1;
        chk("rst in_ready", 0, 8'(ir0), 8'h00);
        step();
        chk("rst out_valid", 0, 8'(ov0), 8'h00);
        chk("rst out_data", 0, 8'(od0), 8'h00);
        chk("rst out_sel", 0, 8'(os0), 8'h00);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", 0, 8'(ir0), 8'h02);
        step();
        chk("post-rst sel", 0, 8'(os0), 8'h01);
        chk("post-rst data", 0, 8'(od0), 8'h0B);
        d0 = {4'bxxxx, 4'hC, 4'hB, 4'h5};
        v0 = 4'b0001;
        step();
        chk("xiso data", 0, 8'(od0), 8'h05);
        chk("xiso known", 0, 8'($isunknown(od0)), 8'h00);
        v0 = '0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes and round-robin (or fixed-priority) arbitration. It generalises the combinational 4:1 data mux into a registered, back-pressured selector: each cycle it picks one requesting input channel, captures its data into an output register and reports which channel won. It sits between several producer streams and a single consumer, such as a shared display or a shared arithmetic unit.

## Interface
- `WIDTH`, default 4: data width per channel, ≥1.
- `N`, default 4: number of input channels, ≥2; need not be a power of two.
- `RR`, default 1: 1 = round-robin arbitration, 0 = fixed priority with channel 0 highest.
- `SEL_W`, derived as `$clog2(N)`: width of the channel index.

- `clk`  in  1: clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  N: per-channel request; bit i belongs to channel i.
- `in_ready`  out  N: per-channel accept; combinational.
- `in_data`  in  N*WIDTH: channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `out_valid`  out  1: output register holds a beat; registered.
- `out_ready`  in  1: consumer accepts the beat.
- `out_data`  out  WIDTH: registered data of the held beat.
- `out_sel`  out  SEL_W: registered index of the channel that supplied `out_data`.

## Operation
- `load = !out_valid || out_ready`. The output register is empty or is being drained this cycle.
- Arbitration is combinational. Search `in_valid` starting at `ptr` and moving upward, wrapping from N-1 to 0. The first set bit is the grant `g`.
  - RR=0: `ptr` is held at 0.
- Exactly one `in_ready` bit may be high: `in_ready[g] = load && |in_valid`. All other bits are 0.
- `in_ready` does not depend on `in_valid[i]` of channel i alone, but it does depend on the other channels' valids. A producer must not withdraw `in_valid` or change `in_data` while `in_ready` is low.
- Transfer on channel g occurs when `in_valid[g] && in_ready[g]`. On the next edge:
  - `out_data` = channel g data
  - `out_sel` = g
  - `out_valid` = 1
  - RR=1: `ptr` = (g+1) mod N, including wrap when g = N-1
- `load` high with no input valid: `out_valid` goes to 0. `out_data` and `out_sel` hold their last values. `ptr` holds.
- `out_valid && !out_ready`: the output register, `ptr` and all `in_ready` bits are frozen or low.
- Fairness (RR=1): with all N channels continuously valid and `out_ready` constantly 1, grants cycle 0,1,…,N-1,0,… One channel can wait at most N-1 beats.
- Reset values:
  - `out_valid` = 0
  - `out_data` = 0
  - `out_sel` = 0
  - `ptr` = 0
  - `in_ready` = 0 while `rst` is high
- Reset mid-operation: the held beat is discarded with no output handshake. The first post-reset grant starts the search from channel 0.
- X handling: `in_data` of non-granted channels may be X and must not propagate. Granted data may be X and is passed through unchanged.

## Timing
- Latency: input handshake at edge k makes `out_valid`/`out_data` visible after edge k, i.e. in cycle k+1.
- Throughput: 1 beat/cycle when `out_ready` is held high. There are no bubbles on a hand-off between channels.
- Combinational paths:
  - `out_ready` → `in_ready`
  - `in_valid` → `in_ready`
  - No combinational path from any input to `out_valid`, `out_data` or `out_sel`.
- Simultaneous drain and load in one cycle is legal. The register is replaced, not emptied.

## Test plan
- **Single-channel sweep.** N=4, W=4, out_ready=1. Drive one channel at a time with data a, b, c, d on channels 0–3. Each beat appears one cycle later with out_sel = 0, 1, 2, 3.
- **Round-robin fairness.** All four valid with constant data {a,b,c,d}, out_ready=1, 8 cycles. out_sel sequence is 0,1,2,3,0,1,2,3 and out_data is a,b,c,d,a,b,c,d.
- **Back-pressure.** Channels 1 and 2 valid, out_ready=0 for 3 cycles after the first load:
  - out_data stays b and out_sel stays 1.
  - in_ready stays 0000.
  - When out_ready rises, channel 2 (c) is loaded in that same cycle.
- **Skip and wrap.** N=3 (non-power-of-two). After a grant to channel 2, only channel 0 is valid. It is granted and `ptr` becomes 1. A following request pattern of {0,1} grants 1 before 0.
- **Fixed priority.** RR=0, all channels valid, 4 beats. out_sel stays 0 throughout.
- **Reset and X isolation.**
  - Assert rst while out_valid=1 holding value 7. Next cycle out_valid=0, out_data=0, out_sel=0. With channels 1 and 3 valid afterwards, channel 1 wins first.
  - Channel 3 data = X while channel 0 is granted. out_data must not be X.
